extream_val_pipe: RTL and testbench

- Pipelined, parametrised successor of the combinational min/max binary-tree finder.
- Reduces 2^(LEVEL-1) entries to one extreme value plus its index.
- Per-transaction min/max mode, per-entry valid mask, sideband tag, valid/ready handshake with backpressure.
- Sits between producers of candidate sets (scheduler/allocator slots) and consumers needing oldest/smallest/largest selection at full clock rate.

---
 rtl/extream_pkg.sv | 30 +++
 rtl/extream_val_pipe_if.sv | 39 +++
 rtl/extream_node.sv | 53 +++++
 rtl/extream_val_pipe.sv | 143 ++++++++++++++
 tb/tb_extream_val_pipe.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/extream_pkg.sv
// Shared types and helpers for the pipelined
// min/max tree reducer.
package extream_pkg;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Operands are pre-extended to this width by
  // the caller so one helper serves any DATA_SZ.
  localparam int CMP_W = 32;

  function automatic logic better(
    input logic [CMP_W-1:0] a,
    input logic [CMP_W-1:0] b,
    input logic             mode,
    input logic             signed_cmp
  );
    logic lt;
    logic gt;
    if (signed_cmp) begin
      lt = $signed(b) < $signed(a);
      gt = $signed(b) > $signed(a);
    end else begin
      lt = b < a;
      gt = b > a;
    end
    return (mode == MODE_MIN) ? lt : gt;
  endfunction

endpackage

// File: rtl/extream_val_pipe_if.sv
// Valid/ready bundle between candidate-set
// producers, the reducer and its consumer.
interface extream_val_pipe_if #(
  parameter int LEVEL   = 3,
  parameter int DATA_SZ = 4,
  parameter int TAG_SZ  = 4
);
  localparam int N      = 2 ** (LEVEL - 1);
  localparam int IDX_SZ = LEVEL - 1;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [N*DATA_SZ-1:0] in_raw;
  logic [N-1:0]         in_mask;
  logic [TAG_SZ-1:0]    in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SZ-1:0]   out_result;
  logic [IDX_SZ-1:0]    out_index;
  logic                 out_found;
  logic [TAG_SZ-1:0]    out_tag;

  modport master (
    output in_valid, in_mode, in_raw,
    output in_mask, in_tag, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_index, out_found, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_raw,
    input  in_mask, in_tag, out_ready,
    output in_ready, out_valid, out_result,
    output out_index, out_found, out_tag
  );

endinterface

// File: rtl/extream_node.sv
// One compare-select cell of the reduction tree;
// ties keep the left (lower-index) child.
module extream_node
  import extream_pkg::*;
#(
  parameter int DATA_SZ = 4,
  parameter int IDX_SZ  = 2,
  parameter int SIGNED  = 0
) (
  input  logic               mode_i,
  input  logic [DATA_SZ-1:0] l_val_i,
  input  logic [IDX_SZ-1:0]  l_idx_i,
  input  logic               l_pres_i,
  input  logic [DATA_SZ-1:0] r_val_i,
  input  logic [IDX_SZ-1:0]  r_idx_i,
  input  logic               r_pres_i,
  output logic [DATA_SZ-1:0] val_o,
  output logic [IDX_SZ-1:0]  idx_o,
  output logic               pres_o
);

  logic [CMP_W-1:0] l_ext;
  logic [CMP_W-1:0] r_ext;
  logic             pick_r;

  if (SIGNED != 0) begin : g_sext
    assign l_ext = CMP_W'($signed(l_val_i));
    assign r_ext = CMP_W'($signed(r_val_i));
  end else begin : g_zext
    assign l_ext = CMP_W'(l_val_i);
    assign r_ext = CMP_W'(r_val_i);
  end

  assign pick_r = r_pres_i & (~l_pres_i |
    better(l_ext, r_ext, mode_i, SIGNED != 0));

  // Select winner; an empty pair yields zeros
  always_comb begin
    val_o  = '0;
    idx_o  = '0;
    pres_o = 1'b0;
    if (pick_r) begin
      val_o  = r_val_i;
      idx_o  = r_idx_i;
      pres_o = 1'b1;
    end else if (l_pres_i) begin
      val_o  = l_val_i;
      idx_o  = l_idx_i;
      pres_o = 1'b1;
    end
  end

endmodule

// File: rtl/extream_val_pipe.sv
// Pipelined min/max reducer: one register stage
// per tree level, global stall on backpressure.
module extream_val_pipe
  import extream_pkg::*;
#(
  parameter int LEVEL   = 3,
  parameter int DATA_SZ = 4,
  parameter int TAG_SZ  = 4,
  parameter int SIGNED  = 0
) (
  input logic              clk,
  input logic              rst_n,
  extream_val_pipe_if.slave bus
);

  localparam int N      = 2 ** (LEVEL - 1);
  localparam int D      = LEVEL - 1;
  localparam int IDX_SZ = LEVEL - 1;

  // Heap-numbered internal nodes: root is 1,
  // children of n are 2n and 2n+1, leaves are
  // N..2N-1 and come straight from the input.
  logic [DATA_SZ-1:0] nv_d [1:N-1];
  logic [DATA_SZ-1:0] nv_q [1:N-1];
  logic [IDX_SZ-1:0]  ni_d [1:N-1];
  logic [IDX_SZ-1:0]  ni_q [1:N-1];
  logic [N-1:1]       np_d;
  logic [N-1:1]       np_q;

  logic               vld_q [1:D];
  logic [TAG_SZ-1:0]  tag_q [1:D];
  // Mode seen by tree level k is mode_c[k-1]
  logic [D-1:0]       mode_c;

  logic en;

  assign en          = ~(bus.out_valid & ~bus.out_ready);
  assign bus.in_ready = en;
  assign mode_c[0]   = bus.in_mode;

  if (D > 1) begin : g_mode
    logic [D-1:1] mode_r;

    // Carry mode alongside data between levels
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_r <= '0;
      end else if (en) begin
        mode_r[1] <= bus.in_mode;
        for (int k = 2; k < D; k++) begin
          mode_r[k] <= mode_r[k-1];
        end
      end
    end

    assign mode_c[D-1:1] = mode_r;
  end

  for (genvar n = 1; n < N; n++) begin : g_node
    localparam int LC = 2 * n;
    localparam int RC = 2 * n + 1;
    localparam int K  = D - ($clog2(n + 1) - 1);

    logic [DATA_SZ-1:0] lv;
    logic [DATA_SZ-1:0] rv;
    logic [IDX_SZ-1:0]  li;
    logic [IDX_SZ-1:0]  ri;
    logic               lp;
    logic               rp;

    if (LC >= N) begin : g_leaf
      assign lv = bus.in_raw[(LC-N)*DATA_SZ +: DATA_SZ];
      assign rv = bus.in_raw[(RC-N)*DATA_SZ +: DATA_SZ];
      assign li = IDX_SZ'(LC - N);
      assign ri = IDX_SZ'(RC - N);
      assign lp = bus.in_mask[LC-N];
      assign rp = bus.in_mask[RC-N];
    end else begin : g_inner
      assign lv = nv_q[LC];
      assign rv = nv_q[RC];
      assign li = ni_q[LC];
      assign ri = ni_q[RC];
      assign lp = np_q[LC];
      assign rp = np_q[RC];
    end

    extream_node #(
      .DATA_SZ (DATA_SZ),
      .IDX_SZ  (IDX_SZ),
      .SIGNED  (SIGNED)
    ) u_node (
      .mode_i   (mode_c[K-1]),
      .l_val_i  (lv),
      .l_idx_i  (li),
      .l_pres_i (lp),
      .r_val_i  (rv),
      .r_idx_i  (ri),
      .r_pres_i (rp),
      .val_o    (nv_d[n]),
      .idx_o    (ni_d[n]),
      .pres_o   (np_d[n])
    );
  end

  // Node result registers, all levels at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 1; n < N; n++) begin
        nv_q[n] <= '0;
        ni_q[n] <= '0;
      end
      np_q <= '0;
    end else if (en) begin
      nv_q <= nv_d;
      ni_q <= ni_d;
      np_q <= np_d;
    end
  end

  // Stage valid and tag shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= D; k++) begin
        vld_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end
    end else if (en) begin
      vld_q[1] <= bus.in_valid;
      tag_q[1] <= bus.in_tag;
      for (int k = 2; k <= D; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign bus.out_valid  = vld_q[D];
  assign bus.out_tag    = tag_q[D];
  assign bus.out_result = nv_q[1];
  assign bus.out_index  = ni_q[1];
  assign bus.out_found  = np_q[1];

endmodule

// File: tb/tb_extream_val_pipe.sv
// Bench for extream_val_pipe: unsigned and signed
// instances driven in lockstep, scoreboarded.
module tb_extream_val_pipe;

  localparam int L  = 3;
  localparam int DW = 4;
  localparam int TW = 4;

  typedef struct packed {
    logic [3:0] val;
    logic [1:0] idx;
    logic       found;
    logic [3:0] tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic        in_valid;
  logic        in_mode;
  logic [15:0] in_raw;
  logic [3:0]  in_mask;
  logic [3:0]  in_tag;
  logic        out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic       stl [2];
  logic [11:0] prv [2];

  always #5 clk = ~clk;

  extream_val_pipe_if #(.LEVEL(L), .DATA_SZ(DW), .TAG_SZ(TW)) b0 ();
  extream_val_pipe_if #(.LEVEL(L), .DATA_SZ(DW), .TAG_SZ(TW)) b1 ();

  assign b0.in_valid  = in_valid;
  assign b0.in_mode   = in_mode;
  assign b0.in_raw    = in_raw;
  assign b0.in_mask   = in_mask;
  assign b0.in_tag    = in_tag;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_mode   = in_mode;
  assign b1.in_raw    = in_raw;
  assign b1.in_mask   = in_mask;
  assign b1.in_tag    = in_tag;
  assign b1.out_ready = out_ready;

  extream_val_pipe #(
    .LEVEL(L), .DATA_SZ(DW), .TAG_SZ(TW), .SIGNED(0)
  ) u_uns (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  extream_val_pipe #(
    .LEVEL(L), .DATA_SZ(DW), .TAG_SZ(TW), .SIGNED(1)
  ) u_sgn (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Linear scan reference: keep first strictly better
  function automatic exp_t model(input logic [15:0] raw,
                                 input logic [3:0] mask,
                                 input logic mode,
                                 input logic sg,
                                 input logic [3:0] tag);
    exp_t e;
    e = '0;
    e.tag = tag;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        logic [3:0] v;
        int a;
        int b;
        v = raw[i*4 +: 4];
        a = sg ? int'($signed(v)) : int'(v);
        b = sg ? int'($signed(e.val)) : int'(e.val);
        if (!e.found || (mode ? (a > b) : (a < b))) begin
          e.val   = v;
          e.idx   = 2'(i);
          e.found = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic mon(input int d, input logic ov,
                     input logic [3:0] r,
                     input logic [1:0] ix,
                     input logic f,
                     input logic [3:0] tg);
    logic [11:0] cur;
    exp_t e;
    int sz;
    cur = {ov, r, ix, f, tg};
    if (stl[d])
      chk($sformatf("hold%0d", d), 32'(cur), 32'(prv[d]));
    prv[d] = cur;
    stl[d] = ov & ~out_ready;
    if (ov && out_ready) begin
      sz = (d == 0) ? q0.size() : q1.size();
      chk($sformatf("spurious%0d", d), 32'(sz > 0), 32'd1);
      if (sz > 0) begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("result%0d", d), 32'(r), 32'(e.val));
        chk($sformatf("index%0d", d), 32'(ix), 32'(e.idx));
        chk($sformatf("found%0d", d), 32'(f), 32'(e.found));
        chk($sformatf("tag%0d", d), 32'(tg), 32'(e.tag));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stl[0] = 1'b0;
      stl[1] = 1'b0;
    end else begin
      mon(0, b0.out_valid, b0.out_result, b0.out_index,
          b0.out_found, b0.out_tag);
      mon(1, b1.out_valid, b1.out_result, b1.out_index,
          b1.out_found, b1.out_tag);
    end
  end

  task automatic send(input logic [15:0] raw,
                      input logic [3:0] mask,
                      input logic mode,
                      input logic [3:0] tag);
    int b;
    b = 0;
    in_valid = 1'b1;
    in_raw   = raw;
    in_mask  = mask;
    in_mode  = mode;
    in_tag   = tag;
    @(negedge clk);
    while (!b0.in_ready && b < 50) begin
      b++;
      @(negedge clk);
    end
    if (b >= 50) chk("ready_timeout", 32'(b), 32'd0);
    q0.push_back(model(raw, mask, mode, 1'b0, tag));
    q1.push_back(model(raw, mask, mode, 1'b1, tag));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((q0.size() != 0 || q1.size() != 0) && b < 40) begin
      @(negedge clk);
      b++;
    end
    if (b >= 40) chk("drain_timeout", 32'(b), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_raw    = '0;
    in_mask   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    stl[0] = 1'b0;
    stl[1] = 1'b0;
    prv[0] = '0;
    prv[1] = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(b0.out_valid), 32'd0);
    chk("rst_result", 32'(b0.out_result), 32'd0);
    chk("rst_index", 32'(b0.out_index), 32'd0);
    chk("rst_found", 32'(b0.out_found), 32'd0);
    chk("rst_tag", 32'(b0.out_tag), 32'd0);
    chk("rst_ready", 32'(b0.in_ready), 32'd1);
    chk("rst_valid_s", 32'(b1.out_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // e0..e3 = 5,2,9,2 ; max -> 9 at index 2
    send(16'h2925, 4'b1111, 1'b1, 4'd3);
    @(negedge clk);
    chk("lat_early", 32'(b0.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(b0.out_valid), 32'd1);
    chk("lat_result", 32'(b0.out_result), 32'd9);
    chk("lat_index", 32'(b0.out_index), 32'd2);
    chk("lat_found", 32'(b0.out_found), 32'd1);
    chk("lat_tag", 32'(b0.out_tag), 32'd3);
    @(posedge clk);
    #1;

    send(16'h2925, 4'b1111, 1'b0, 4'd4);
    send(16'h2925, 4'b1010, 1'b0, 4'd5);
    send(16'h2925, 4'b0000, 1'b1, 4'd6);
    send(16'h2925, 4'b0100, 1'b0, 4'd7);
    send(16'h2925, 4'b0100, 1'b1, 4'd8);
    send(16'h7777, 4'b1111, 1'b0, 4'd9);
    drain();

    // Four back-to-back, then 3 cycles of stall
    fork
      begin
        send(16'h3C81, 4'b1111, 1'b0, 4'hA);
        send(16'h3C81, 4'b1111, 1'b1, 4'hB);
        send(16'hE0F4, 4'b0111, 1'b0, 4'hC);
        send(16'hE0F4, 4'b1110, 1'b1, 4'hD);
      end
      begin
        int b;
        b = 0;
        @(negedge clk);
        while (!b0.out_valid && b < 20) begin
          @(negedge clk);
          b++;
        end
        if (b >= 20) chk("first_timeout", 32'(b), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready", 32'(b0.in_ready), 32'd0);
          chk("stall_ready_s", 32'(b1.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("lost0", 32'(q0.size()), 32'd0);
    chk("lost1", 32'(q1.size()), 32'd0);

    // e0..e3 = F,1,8,0 ; signed min -8, max 1
    send(16'h081F, 4'b1111, 1'b0, 4'h1);
    send(16'h081F, 4'b1111, 1'b1, 4'h2);
    drain();

    // Reset with two transactions in flight
    send(16'h1234, 4'b1111, 1'b1, 4'hE);
    send(16'h4321, 4'b1111, 1'b0, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(b0.out_valid), 32'd0);
    chk("mid_valid_s", 32'(b1.out_valid), 32'd0);
    chk("mid_ready", 32'(b0.in_ready), 32'd1);
    chk("mid_result", 32'(b0.out_result), 32'd0);
    chk("mid_tag", 32'(b0.out_tag), 32'd0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_valid", 32'(b0.out_valid), 32'd0);
      chk("post_valid_s", 32'(b1.out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
